// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding select codes and the memory-wait timeout.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_EX  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;
  localparam logic [1:0]  FWD_WB  = 2'b11;

  localparam logic [3:0]  TIMEOUT_LIMIT = 4'd15;
  localparam logic [3:0]  REG_PC        = 4'd15;
  localparam logic [15:0] STALL_MAX     = 16'hFFFF;

  // True when a used source register is written by a stage with its write enable set.
  function automatic logic src_hit(input logic use_src, input logic [3:0] src,
                                   input logic rf_en, input logic [3:0] rd);
    return use_src && rf_en && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding mux select: youngest producing stage wins, R15 never forwards.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [3:0] src,
  input  logic       use_src,
  input  logic [3:0] rd_ex,
  input  logic [3:0] rd_mem,
  input  logic [3:0] rd_wb,
  input  logic       rf_en_ex,
  input  logic       rf_en_mem,
  input  logic       rf_en_wb,
  output logic [1:0] sel
);

  // Priority match EX > MEM > WB.
  always_comb begin
    sel = FWD_RF;
    if (src == REG_PC) begin
      sel = FWD_RF;
    end else if (src_hit(use_src, src, rf_en_ex, rd_ex)) begin
      sel = FWD_EX;
    end else if (src_hit(use_src, src, rf_en_mem, rd_mem)) begin
      sel = FWD_MEM;
    end else if (src_hit(use_src, src, rf_en_wb, rd_wb)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use bubble, branch flush and
// data-memory wait freeze with a sticky timeout and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rn_id,
  input  logic [3:0]  rm_id,
  input  logic [3:0]  rd_id,
  input  logic        use_rn,
  input  logic        use_rm,
  input  logic        use_rd,
  input  logic [3:0]  rd_ex,
  input  logic [3:0]  rd_mem,
  input  logic [3:0]  rd_wb,
  input  logic        rf_en_ex,
  input  logic        rf_en_mem,
  input  logic        rf_en_wb,
  input  logic        load_ex,
  input  logic        branch_taken,
  input  logic        datamem_en_mem,
  input  logic        mem_ready,
  output logic        pc_le,
  output logic        ifid_le,
  output logic        ifid_flush,
  output logic        nop_sel,
  output logic        pipe_freeze,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_c,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  state_t      state_r, state_next_s;
  logic [3:0]  wait_cnt_r, wait_cnt_next_s;
  logic        mem_timeout_r, timeout_set_s;
  logic [15:0] stall_count_r;
  logic [1:0]  fwd_a_s, fwd_b_s, fwd_c_s;
  logic        load_use_s;

  fwd_select u_fwd_rn (.src(rn_id), .use_src(use_rn), .rd_ex(rd_ex), .rd_mem(rd_mem),
                       .rd_wb(rd_wb), .rf_en_ex(rf_en_ex), .rf_en_mem(rf_en_mem),
                       .rf_en_wb(rf_en_wb), .sel(fwd_a_s));
  fwd_select u_fwd_rm (.src(rm_id), .use_src(use_rm), .rd_ex(rd_ex), .rd_mem(rd_mem),
                       .rd_wb(rd_wb), .rf_en_ex(rf_en_ex), .rf_en_mem(rf_en_mem),
                       .rf_en_wb(rf_en_wb), .sel(fwd_b_s));
  fwd_select u_fwd_rd (.src(rd_id), .use_src(use_rd), .rd_ex(rd_ex), .rd_mem(rd_mem),
                       .rd_wb(rd_wb), .rf_en_ex(rf_en_ex), .rf_en_mem(rf_en_mem),
                       .rf_en_wb(rf_en_wb), .sel(fwd_c_s));

  assign load_use_s = load_ex && (src_hit(use_rn, rn_id, rf_en_ex, rd_ex) ||
                                  src_hit(use_rm, rm_id, rf_en_ex, rd_ex) ||
                                  src_hit(use_rd, rd_id, rf_en_ex, rd_ex));

  assign fwd_a       = reset ? FWD_RF : fwd_a_s;
  assign fwd_b       = reset ? FWD_RF : fwd_b_s;
  assign fwd_c       = reset ? FWD_RF : fwd_c_s;
  assign mem_timeout = mem_timeout_r;
  assign stall_count = stall_count_r;

  // Next-state and pipeline control; a memory stall masks branch and load-use.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    timeout_set_s   = 1'b0;
    pc_le           = 1'b1;
    ifid_le         = 1'b1;
    ifid_flush      = 1'b0;
    nop_sel         = 1'b0;
    pipe_freeze     = 1'b0;
    if (reset) begin
      ifid_flush      = 1'b1;
      nop_sel         = 1'b1;
      state_next_s    = ST_RUN;
      wait_cnt_next_s = 4'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (datamem_en_mem && !mem_ready) begin
            pc_le           = 1'b0;
            ifid_le         = 1'b0;
            pipe_freeze     = 1'b1;
            state_next_s    = ST_MEM_WAIT;
            wait_cnt_next_s = 4'd0;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
            nop_sel    = 1'b1;
          end else if (load_use_s) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            nop_sel = 1'b1;
          end else begin
            nop_sel = 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          pc_le       = 1'b0;
          ifid_le     = 1'b0;
          pipe_freeze = 1'b1;
          if (mem_ready) begin
            state_next_s    = ST_RUN;
            wait_cnt_next_s = 4'd0;
          end else if (wait_cnt_r == (TIMEOUT_LIMIT - 4'd1)) begin
            state_next_s    = ST_ERROR;
            wait_cnt_next_s = TIMEOUT_LIMIT;
            timeout_set_s   = 1'b1;
          end else begin
            wait_cnt_next_s = wait_cnt_r + 4'd1;
          end
        end
        ST_ERROR: begin
          pc_le       = 1'b0;
          ifid_le     = 1'b0;
          pipe_freeze = 1'b1;
        end
        default: begin
          state_next_s    = ST_RUN;
          wait_cnt_next_s = 4'd0;
        end
      endcase
    end
  end

  // State, wait counter, sticky timeout and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= 4'd0;
      mem_timeout_r <= 1'b0;
      stall_count_r <= 16'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      if (timeout_set_s) begin
        mem_timeout_r <= 1'b1;
      end
      if (!pc_le && (stall_count_r != STALL_MAX)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with an expectation queue.
module tb_pipeline_hazard_ctrl;

  logic        clk, reset;
  logic [3:0]  rn_id, rm_id, rd_id, rd_ex, rd_mem, rd_wb;
  logic        use_rn, use_rm, use_rd, rf_en_ex, rf_en_mem, rf_en_wb;
  logic        load_ex, branch_taken, datamem_en_mem, mem_ready;
  logic        pc_le, ifid_le, ifid_flush, nop_sel, pipe_freeze, mem_timeout;
  logic [1:0]  fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stall   = 16'd0;
  logic        exp_timeout = 1'b0;
  logic [27:0] exp_q[$];
  string       tag_q[$];

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rn_id(rn_id), .rm_id(rm_id), .rd_id(rd_id),
    .use_rn(use_rn), .use_rm(use_rm), .use_rd(use_rd),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_en_ex(rf_en_ex), .rf_en_mem(rf_en_mem), .rf_en_wb(rf_en_wb),
    .load_ex(load_ex), .branch_taken(branch_taken),
    .datamem_en_mem(datamem_en_mem), .mem_ready(mem_ready),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush),
    .nop_sel(nop_sel), .pipe_freeze(pipe_freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {rn_id, rm_id, rd_id, rd_ex, rd_mem, rd_wb} = '0;
    {use_rn, use_rm, use_rd, rf_en_ex, rf_en_mem, rf_en_wb} = '0;
    {load_ex, branch_taken, datamem_en_mem, mem_ready} = '0;
  endtask

  // Pop the oldest expectation and compare it against the settled outputs.
  task automatic check_out();
    logic [27:0] e;
    string       t;
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "pc_le",       {15'd0, pc_le},       {15'd0, e[27]});
    cmp(t, "ifid_le",     {15'd0, ifid_le},     {15'd0, e[26]});
    cmp(t, "ifid_flush",  {15'd0, ifid_flush},  {15'd0, e[25]});
    cmp(t, "nop_sel",     {15'd0, nop_sel},     {15'd0, e[24]});
    cmp(t, "pipe_freeze", {15'd0, pipe_freeze}, {15'd0, e[23]});
    cmp(t, "fwd_a",       {14'd0, fwd_a},       {14'd0, e[22:21]});
    cmp(t, "fwd_b",       {14'd0, fwd_b},       {14'd0, e[20:19]});
    cmp(t, "fwd_c",       {14'd0, fwd_c},       {14'd0, e[18:17]});
    cmp(t, "mem_timeout", {15'd0, mem_timeout}, {15'd0, e[16]});
    cmp(t, "stall_count", stall_count,          e[15:0]);
    if (!e[27] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  // Inputs are already driven; queue the expectation, check it, advance one cycle.
  task automatic step(input string tag, input logic pc, input logic ifid, input logic fl,
                      input logic nop, input logic frz,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fc);
    exp_q.push_back({pc, ifid, fl, nop, frz, fa, fb, fc, exp_timeout, exp_stall});
    tag_q.push_back(tag);
    check_out();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    rn_id = 4'd3; use_rn = 1'b1; rd_ex = 4'd3; rf_en_ex = 1'b1;
    @(negedge clk);
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    clear_inputs();
    step("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    rn_id = 4'd3; use_rn = 1'b1; rd_ex = 4'd3; rf_en_ex = 1'b1;
    step("fwd_ex", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00);

    clear_inputs();
    rd_ex = 4'd5; load_ex = 1'b1; rf_en_ex = 1'b1; rm_id = 4'd5; use_rm = 1'b1;
    step("load_use", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00);
    clear_inputs();
    step("after_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    rd_ex = 4'd5; load_ex = 1'b1; rf_en_ex = 1'b1; rm_id = 4'd5; use_rm = 1'b1;
    branch_taken = 1'b1;
    step("lu_branch", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00);
    clear_inputs();
    step("after_br", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    rd_ex = 4'd7; rd_mem = 4'd7; rd_wb = 4'd7; rf_en_mem = 1'b1; rf_en_wb = 1'b1;
    rn_id = 4'd7; use_rn = 1'b1; rm_id = 4'd7; rd_id = 4'd7; use_rd = 1'b1;
    step("fwd_mem", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10);
    clear_inputs();
    rd_wb = 4'd2; rf_en_wb = 1'b1; rd_id = 4'd2; use_rd = 1'b1;
    step("fwd_wb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
    clear_inputs();
    rn_id = 4'd15; use_rn = 1'b1; rd_ex = 4'd15; rf_en_ex = 1'b1;
    step("r15", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    clear_inputs();
    load_ex = 1'b1; rf_en_ex = 1'b1; rd_ex = 4'd4; rd_id = 4'd4; use_rd = 1'b1;
    step("lu_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01);
    clear_inputs();
    load_ex = 1'b1; rf_en_ex = 1'b1; rd_ex = 4'd4; rn_id = 4'd4;
    step("lu_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    clear_inputs();
    datamem_en_mem = 1'b1; mem_ready = 1'b1;
    step("mem_fast", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    mem_ready = 1'b0; branch_taken = 1'b1;
    step("mem_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    branch_taken = 1'b0;
    step("mem_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    step("mem_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    mem_ready = 1'b1;
    step("mem_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    clear_inputs();
    step("mem_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    datamem_en_mem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 16) exp_timeout = 1'b1;
      step("timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    end
    clear_inputs();
    mem_ready = 1'b1;
    step("err_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);

    repeat (65540) @(negedge clk);
    exp_stall = 16'hFFFF;
    step("stall_sat", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);

    reset = 1'b1;
    step("err_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    exp_stall = 16'd0; exp_timeout = 1'b0;
    reset = 1'b0;
    clear_inputs();
    step("post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    datamem_en_mem = 1'b1;
    step("mw_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    step("mw_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    reset = 1'b1;
    step("mw_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    exp_stall = 16'd0;
    reset = 1'b0;
    clear_inputs();
    step("mw_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 rn_id, rm_id, rd_id  in  4 each  ID-stage source registers (rd_id = store data source).
REQ-005 use_rn, use_rm, use_rd  in  1 each  ID source-valid flags.
REQ-006 rd_ex, rd_mem, rd_wb  in  4 each  destination register per stage.
REQ-007 rf_en_ex, rf_en_mem, rf_en_wb  in  1 each  register-write enable per stage.
REQ-008 load_ex  in  1  EX instruction is a load.
REQ-009 branch_taken  in  1  branch resolved taken in EX.
REQ-010 datamem_en_mem  in  1  MEM stage accessing data memory.
REQ-011 mem_ready  in  1  data memory completes access this cycle.
REQ-012 pc_le, ifid_le  out  1 each  PC and IF/ID load enables.
REQ-013 ifid_flush  out  1  IF/ID reset request.
REQ-014 nop_sel  out  1  inject all-zero control word into ID/EXE.
REQ-015 pipe_freeze  out  1  hold ID/EXE, EXE/MEM, MEM/WB.
REQ-016 fwd_a, fwd_b, fwd_c  out  2 each  operand select for rn/rm/rd: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 mem_timeout  out  1  sticky error flag.
REQ-018 stall_count  out  16  saturating count of stalled cycles.

Function
REQ-019 FSM states SHALL be RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-020 Forwarding SHALL be combinational: per operand, first match in order EX, MEM, WB with rf_en set, use flag set, rd equal to source; else 00.
REQ-021 R15 source SHALL never forward (select 00).
REQ-022 Load-use hazard = RUN, load_ex, rf_en_ex, and any used ID source equal to rd_ex.
REQ-023 On load-use in RUN, same cycle: pc_le=0, ifid_le=0, nop_sel=1, ifid_flush=0; no state change (single bubble).
REQ-024 On branch_taken in RUN, same cycle: pc_le=1, ifid_le=1, ifid_flush=1, nop_sel=1; branch overrides load-use.
REQ-025 In RUN with datamem_en_mem=1 and mem_ready=0: pc_le=0, ifid_le=0, pipe_freeze=1, nop_sel=0; next state MEM_WAIT; branch_taken and load-use ignored that cycle.
REQ-026 MEM_WAIT SHALL hold pc_le=0, ifid_le=0, pipe_freeze=1; wait counter (4 bit) increments each cycle.
REQ-027 MEM_WAIT with mem_ready=1: outputs still frozen that cycle, next state RUN, wait counter cleared.
REQ-028 Wait counter reaching 15 without mem_ready: next state ERROR, mem_timeout set.
REQ-029 ERROR SHALL freeze as MEM_WAIT and exit only by reset; mem_timeout stays 1.
REQ-030 Otherwise in RUN: pc_le=1, ifid_le=1, ifid_flush=0, nop_sel=0, pipe_freeze=0.
REQ-031 stall_count SHALL increment on any cycle with pc_le=0, saturating at 0xFFFF.

Reset
REQ-032 On reset: state RUN, wait counter 0, mem_timeout 0, stall_count 0.
REQ-033 During the reset cycle outputs SHALL be pc_le=1, ifid_le=1, ifid_flush=1, nop_sel=1, pipe_freeze=0, fwd_*=00.
REQ-034 Reset mid-MEM_WAIT or ERROR SHALL return to RUN on the next edge.

Structure
REQ-035 State encoding, forward-select codes (FWD_RF/EX/MEM/WB) and timeout limit 15 SHALL live in the shared pipeline package.
REQ-036 One sub-module fwd_select SHALL be instantiated three times (rn, rm, rd).

Verification
REQ-037 rn_id=3 use_rn=1, rd_ex=3 rf_en_ex=1 load_ex=0 -> fwd_a=01, no stall.
REQ-038 rd_ex=5 load_ex=1 rf_en_ex=1, rm_id=5 use_rm=1 -> one cycle pc_le=0 ifid_le=0 nop_sel=1; stall_count=1.
REQ-039 Same load-use plus branch_taken=1 -> ifid_flush=1 nop_sel=1 pc_le=1, stall_count unchanged.
REQ-040 datamem_en_mem=1, mem_ready low 3 cycles then high -> freeze 4 cycles, RUN on 5th, stall_count=4.
REQ-041 mem_ready held low 20 cycles -> ERROR after 15 MEM_WAIT cycles, mem_timeout=1; reset -> RUN, mem_timeout=0.
REQ-042 rd_mem=7 and rd_wb=7 both writing, rn_id=7 -> fwd_a=10; rn_id=15 with rd_ex=15 -> fwd_a=00.
